ro_puf_ctrl: RTL and testbench

Challenge/response sequencer for the 16-instance ring-oscillator PUF array. It accepts a challenge that selects two oscillators. It clears them, enables only that pair, and counts their rising edges over a fixed clk window. It then compares the counts and returns a one-bit response with a done pulse. It sits between the host/test logic and the `ro_out`/`enable`/`rst` pins of the oscillator instances. It is the only driver of those pins.

---
 rtl/ro_puf_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ro_puf_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF challenge/response sequencer.
// Clears and enables one oscillator pair, counts its edges over a window, compares the counts.
`timescale 1ns/1ps
module ro_puf_ctrl #(
    parameter int N_RO       = 16,
    parameter int CNT_W      = 16,
    parameter int RST_CYC    = 4,
    parameter int SETTLE_CYC = 8,
    parameter int WINDOW     = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       challenge,
    input  logic [N_RO-1:0]  ro_out,
    output logic [N_RO-1:0]  ro_en,
    output logic             ro_rst,
    output logic             busy,
    output logic             done,
    output logic             response,
    output logic             tie,
    output logic             err,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b
);

    localparam int TMR_W = $clog2(WINDOW + RST_CYC + SETTLE_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_SETTLE,
        S_COUNT,
        S_CMP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [3:0]        sel_a_q, sel_a_d;
    logic [3:0]        sel_b_q, sel_b_d;
    logic [CNT_W-1:0]  cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]  cnt_b_q, cnt_b_d;
    logic [CNT_W-1:0]  count_a_q, count_a_d;
    logic [CNT_W-1:0]  count_b_q, count_b_d;
    logic              response_q, response_d;
    logic              tie_q, tie_d;
    logic              err_q, err_d;

    logic [N_RO-1:0]   sync1_q, sync2_q, prev_q;
    logic [N_RO-1:0]   rise;
    logic              edge_a, edge_b;

    assign rise   = sync2_q & ~prev_q;
    assign edge_a = rise[sel_a_q];
    assign edge_b = rise[sel_b_q];

    // Two-flop synchronizer plus a history flop for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= ro_out;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Sequencer state, phase timer, edge counters and held results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            sel_a_q    <= '0;
            sel_b_q    <= '0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            count_a_q  <= '0;
            count_b_q  <= '0;
            response_q <= 1'b0;
            tie_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            sel_a_q    <= sel_a_d;
            sel_b_q    <= sel_b_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            count_a_q  <= count_a_d;
            count_b_q  <= count_b_d;
            response_q <= response_d;
            tie_q      <= tie_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic: phase sequencing, saturating counts, result capture
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        sel_a_d    = sel_a_q;
        sel_b_d    = sel_b_q;
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;
        count_a_d  = count_a_q;
        count_b_d  = count_b_q;
        response_d = response_q;
        tie_d      = tie_q;
        err_d      = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_a_d    = challenge[7:4];
                    sel_b_d    = challenge[3:0];
                    tmr_d      = '0;
                    cnt_a_d    = '0;
                    cnt_b_d    = '0;
                    count_a_d  = '0;
                    count_b_d  = '0;
                    response_d = 1'b0;
                    tie_d      = 1'b0;
                    err_d      = 1'b0;
                    if (challenge[7:4] == challenge[3:0]) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RST;
                    end
                end
            end
            S_RST: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (tmr_q == TMR_W'(RST_CYC - 1)) begin
                    tmr_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                cnt_a_d = '0;
                cnt_b_d = '0;
                tmr_d   = tmr_q + TMR_W'(1);
                if (tmr_q == TMR_W'(SETTLE_CYC - 1)) begin
                    tmr_d   = '0;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (edge_a && (cnt_a_q != '1)) cnt_a_d = cnt_a_q + CNT_W'(1);
                if (edge_b && (cnt_b_q != '1)) cnt_b_d = cnt_b_q + CNT_W'(1);
                tmr_d = tmr_q + TMR_W'(1);
                if (tmr_q == TMR_W'(WINDOW - 1)) begin
                    tmr_d   = '0;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                count_a_d  = cnt_a_q;
                count_b_d  = cnt_b_q;
                response_d = (cnt_a_q > cnt_b_q);
                tie_d      = (cnt_a_q == cnt_b_q);
                state_d    = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Oscillator pin drive decoded from the registered state
    always_comb begin
        ro_en = '0;
        if ((state_q == S_SETTLE) || (state_q == S_COUNT)) begin
            ro_en[sel_a_q] = 1'b1;
            ro_en[sel_b_q] = 1'b1;
        end
    end

    assign ro_rst   = (state_q == S_RST);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign response = response_q;
    assign tie      = tie_q;
    assign err      = err_q;
    assign count_a  = count_a_q;
    assign count_b  = count_b_q;

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Bench for ro_puf_ctrl: behavioural oscillators, directed and random challenges.
// Two instances: a 16-bit/300-cycle window unit and a 4-bit/100-cycle saturation unit.
`timescale 1ns/1ps
module tb_ro_puf_ctrl;

    localparam int WM  = 300;
    localparam int WS  = 100;
    localparam int LAT = 4 + 8 + WM + 1;
    localparam int TM  = WM * 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int half_m[16];

    logic        start_m, start_s;
    logic [7:0]  ch_m, ch_s;
    wire  [15:0] ro_m, ro_s;
    logic [15:0] en_m, en_s;
    logic        rr_m, busy_m, done_m, resp_m, tie_m, err_m;
    logic        rr_s, busy_s, done_s, resp_s, tie_s, err_s;
    logic [15:0] ca_m, cb_m;
    logic [3:0]  ca_s, cb_s;

    ro_puf_ctrl #(.CNT_W(16), .WINDOW(WM)) u_main (
        .clk(clk), .rst(rst), .start(start_m), .challenge(ch_m),
        .ro_out(ro_m), .ro_en(en_m), .ro_rst(rr_m), .busy(busy_m),
        .done(done_m), .response(resp_m), .tie(tie_m), .err(err_m),
        .count_a(ca_m), .count_b(cb_m)
    );

    ro_puf_ctrl #(.CNT_W(4), .WINDOW(WS)) u_sat (
        .clk(clk), .rst(rst), .start(start_s), .challenge(ch_s),
        .ro_out(ro_s), .ro_en(en_s), .ro_rst(rr_s), .busy(busy_s),
        .done(done_s), .response(resp_s), .tie(tie_s), .err(err_s),
        .count_a(ca_s), .count_b(cb_s)
    );

    // Behavioural oscillators: start low 3 ns after enable, toggle every half period
    for (genvar g = 0; g < 16; g++) begin : g_ro
        logic rm, rs;
        assign ro_m[g] = rm;
        assign ro_s[g] = rs;
        always begin
            rm = 1'b0;
            wait (en_m[g] === 1'b1);
            #3;
            while (en_m[g] === 1'b1) begin
                #(half_m[g]);
                rm = ~rm;
            end
        end
        always begin
            rs = 1'b0;
            wait (en_s[g] === 1'b1);
            #3;
            while (en_s[g] === 1'b1) begin
                #15;
                rs = ~rs;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // An edge count over a window of t ns must lie strictly within one of t/p
    task automatic chk_rng(input string tag, input int c, input int p, input int t);
        checks++;
        assert ((c * p > t - p) && (c * p < t + p)) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d/%0d +-1", tag, c, t, p);
        end
    endtask

    task automatic txn(input logic [7:0] ch, input int poke,
                       output int lat, output int kend, output int nd,
                       output logic en_seen, output logic rr_seen,
                       output logic [31:0] clr);
        lat = -1; kend = -1; nd = 0; en_seen = 1'b0; rr_seen = 1'b0;
        @(negedge clk);
        start_m = 1'b1;
        ch_m    = ch;
        @(negedge clk);
        start_m = 1'b0;
        clr = {14'd0, resp_m, tie_m, ca_m | cb_m};
        for (int k = 0; k < 2000; k++) begin
            if (k == poke) begin
                start_m = 1'b1;
                ch_m    = 8'h55;
            end
            if (k == poke + 1) start_m = 1'b0;
            if (en_m != 16'd0) en_seen = 1'b1;
            if (rr_m) rr_seen = 1'b1;
            if (done_m) begin
                if (lat < 0) lat = k;
                nd++;
            end
            if (!busy_m) begin
                kend = k;
                break;
            end
            @(negedge clk);
        end
        start_m = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, kend, nd, pa, pb, a, b;
        logic es, rs;
        logic [31:0] clr;
        start_m = 1'b0; start_s = 1'b0;
        ch_m = 8'h00; ch_s = 8'h00;
        for (int i = 0; i < 16; i++) half_m[i] = 50;

        #12;
        chk("rst_ro_en", 32'(en_m), 0);
        chk("rst_busy", 32'(busy_m), 0);
        chk("rst_done", 32'(done_m), 0);
        chk("rst_ro_rst", 32'(rr_m), 0);
        chk("rst_results", {27'd0, resp_m, tie_m, err_m, 2'd0}, 0);
        chk("rst_counts", 32'(ca_m | cb_m), 0);
        #13 rst = 1'b0;

        half_m[3] = 30;
        half_m[9] = 45;
        txn(8'h39, -1, lat, kend, nd, es, rs, clr);
        chk("a39_latency", lat, LAT);
        chk("a39_done_once", nd, 1);
        chk("a39_busy_end", kend, LAT + 1);
        chk("a39_cleared", clr, 0);
        chk_rng("a39_count_a", 32'(ca_m), 60, TM);
        chk_rng("a39_count_b", 32'(cb_m), 90, TM);
        chk("a39_resp", 32'(resp_m), 1);
        chk("a39_tie", 32'(tie_m), 0);
        chk("a39_err", 32'(err_m), 0);
        chk("a39_en_seen", 32'(es), 1);
        chk("a39_rst_seen", 32'(rs), 1);
        repeat (5) @(negedge clk);
        chk("a39_held_resp", 32'(resp_m), 1);
        chk_rng("a39_held_a", 32'(ca_m), 60, TM);

        txn(8'h93, -1, lat, kend, nd, es, rs, clr);
        chk("a93_resp", 32'(resp_m), 0);
        chk_rng("a93_count_a", 32'(ca_m), 90, TM);
        chk_rng("a93_count_b", 32'(cb_m), 60, TM);

        txn(8'h55, -1, lat, kend, nd, es, rs, clr);
        chk("a55_latency", lat, 0);
        chk("a55_busy_end", kend, 1);
        chk("a55_err", 32'(err_m), 1);
        chk("a55_resp", 32'(resp_m), 0);
        chk("a55_en_seen", 32'(es), 0);
        chk("a55_rst_seen", 32'(rs), 0);

        half_m[3] = 40;
        half_m[9] = 40;
        txn(8'h39, -1, lat, kend, nd, es, rs, clr);
        chk("tie_tie", 32'(tie_m), 1);
        chk("tie_resp", 32'(resp_m), 0);
        chk_rng("tie_count_a", 32'(ca_m), 80, TM);

        half_m[3] = 30;
        half_m[9] = 45;
        txn(8'h39, 50, lat, kend, nd, es, rs, clr);
        chk("poke_latency", lat, LAT);
        chk("poke_err", 32'(err_m), 0);
        chk("poke_resp", 32'(resp_m), 1);
        chk("poke_done_once", nd, 1);

        @(negedge clk);
        start_s = 1'b1;
        ch_s    = 8'h12;
        @(negedge clk);
        start_s = 1'b0;
        nd = 0;
        for (int k = 0; k < 400; k++) begin
            if (done_s) nd++;
            if (!busy_s) break;
            @(negedge clk);
        end
        chk("sat_done", nd, 1);
        chk("sat_count_a", 32'(ca_s), 15);
        chk("sat_count_b", 32'(cb_s), 15);
        chk("sat_tie", 32'(tie_s), 1);

        @(negedge clk);
        start_m = 1'b1;
        ch_m    = 8'h39;
        @(negedge clk);
        start_m = 1'b0;
        repeat (162) @(negedge clk);
        chk("mid_busy_before", 32'(busy_m), 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_ro_en", 32'(en_m), 0);
        chk("mid_busy", 32'(busy_m), 0);
        chk("mid_count_a", 32'(ca_m), 0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_m || busy_m) nd++;
        end
        chk("mid_no_done", nd, 0);
        txn(8'h39, -1, lat, kend, nd, es, rs, clr);
        chk("post_latency", lat, LAT);
        chk("post_resp", 32'(resp_m), 1);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 16; i++) half_m[i] = 5 * $urandom_range(3, 20);
            a = $urandom_range(0, 15);
            b = (t == 3) ? a : $urandom_range(0, 15);
            txn({a[3:0], b[3:0]}, -1, lat, kend, nd, es, rs, clr);
            if (a == b) begin
                chk("rnd_err", 32'(err_m), 1);
                chk("rnd_eq_latency", lat, 0);
            end else begin
                pa = 2 * half_m[a];
                pb = 2 * half_m[b];
                chk("rnd_latency", lat, LAT);
                chk("rnd_err", 32'(err_m), 0);
                chk_rng("rnd_count_a", 32'(ca_m), pa, TM);
                chk_rng("rnd_count_b", 32'(cb_m), pb, TM);
                if (TM * (pb - pa) >= 2 * pa * pb) begin
                    chk("rnd_resp", 32'(resp_m), 1);
                    chk("rnd_tie", 32'(tie_m), 0);
                end else if (TM * (pa - pb) >= 2 * pa * pb) begin
                    chk("rnd_resp", 32'(resp_m), 0);
                    chk("rnd_tie", 32'(tie_m), 0);
                end else if (pa == pb) begin
                    chk("rnd_tie", 32'(tie_m), 1);
                    chk("rnd_resp", 32'(resp_m), 0);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
